// File: rtl/gameplay_pkg.sv
// Shared definitions for the gameplay timers: state encoding, default
// timing constants and the prescaler width helper.
package gameplay_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_COOL = 2'd2;

  localparam int PRESCALE_DEF   = 4;
  localparam int COOL_TICKS_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_HOLD = ST_HOLD,
    S_COOL = ST_COOL
  } state_e;

  // A prescaler of 1 still needs a one-bit counter.
  function automatic int ps_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle tick every PRESCALE cycles; clr restarts the
// phase so the first tick lands PRESCALE edges after the clearing edge.
module tick_prescaler
  import gameplay_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clr,
  output logic tick
);

  localparam int PS_W = ps_width(PRESCALE);

  logic [PS_W-1:0] cnt_q;
  logic [PS_W-1:0] cnt_d;

  assign tick = (cnt_q == PS_W'(PRESCALE - 1));

  always_comb begin
    cnt_d = cnt_q + PS_W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pulse_stretch_timer.sv
// Stretches a single-cycle trigger into a level held for hold_len prescaled
// ticks, followed by an optional cooldown gap before the next window.
module pulse_stretch_timer
  import gameplay_pkg::*;
#(
  parameter int PRESCALE   = PRESCALE_DEF,
  parameter int CNT_W      = 8,
  parameter int COOL_TICKS = COOL_TICKS_DEF
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             trig_in,
  input  logic             cancel,
  input  logic             retrig_en,
  input  logic [CNT_W-1:0] hold_len,
  output logic             level_out,
  output logic             done_pulse,
  output logic             dropped,
  output logic [CNT_W-1:0] remaining
);

  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOL_TICKS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             level_q, done_q, done_d, drop_q, drop_d;
  logic             tick, clr, idle_like, end_win;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .n_reset(n_reset),
    .clr    (clr),
    .tick   (tick)
  );

  // The last cooldown tick behaves as IDLE so a trigger on that edge is taken.
  assign idle_like = (state_q == S_COOL) ? (tick && (cnt_q <= CNT_W'(1)))
                                         : (state_q != S_HOLD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    end_win = 1'b0;

    if (state_q == S_HOLD) begin
      if (cancel) begin
        drop_d  = trig_in;
        end_win = 1'b1;
      end else if (trig_in && retrig_en && (hold_len != '0)) begin
        cnt_d = hold_len;
        clr   = 1'b1;
      end else begin
        drop_d = trig_in;
        if (tick) begin
          if (cnt_q <= CNT_W'(1)) begin
            end_win = 1'b1;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
    end else if (idle_like) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      if (trig_in) begin
        if (cancel || (hold_len == '0)) begin
          drop_d = 1'b1;
        end else begin
          state_d = S_HOLD;
          cnt_d   = hold_len;
          clr     = 1'b1;
        end
      end
    end else begin
      drop_d = trig_in;
      if (tick) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    if (end_win) begin
      if (COOL_TICKS == 0) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = S_COOL;
        cnt_d   = COOL_LOAD;
        clr     = 1'b1;
      end
    end

    rem_d = (state_d == S_HOLD) ? cnt_d : '0;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      level_q <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      level_q <= (state_d == S_HOLD);
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign level_out  = level_q;
  assign done_pulse = done_q;
  assign dropped    = drop_q;
  assign remaining  = rem_q;

endmodule

// File: tb/tb_pulse_stretch_timer.sv
// Bench for pulse_stretch_timer: directed scenarios plus random traffic, all
// checked each cycle against a window/deadline model in absolute cycle numbers.
module tb_pulse_stretch_timer;

  localparam int P = 4;
  localparam int W = 8;
  localparam int C = 2;

  logic         clk = 1'b0;
  logic         n_reset = 1'b0;
  logic         trig_in = 1'b0, cancel = 1'b0, retrig_en = 1'b0;
  logic [W-1:0] hold_len = '0;
  logic         level_out, done_pulse, dropped;
  logic [W-1:0] remaining;

  logic         trig1 = 1'b0, zero1 = 1'b0;
  logic [W-1:0] hold1 = '0;
  logic         level1, done1, drop1;
  logic [W-1:0] remaining1;

  int total = 0, bad = 0;
  int cyc = 0;
  bit m_win = 1'b0, m_done = 1'b0, m_drop = 1'b0;
  int m_fall = 0, m_idle_from = 0;
  int hi_cnt = 0, done_cnt = 0, drop_cnt = 0;
  int n1;

  always #5 clk = ~clk;

  pulse_stretch_timer #(.PRESCALE(P), .CNT_W(W), .COOL_TICKS(C)) u_dut (
    .clk(clk), .n_reset(n_reset), .trig_in(trig_in), .cancel(cancel),
    .retrig_en(retrig_en), .hold_len(hold_len), .level_out(level_out),
    .done_pulse(done_pulse), .dropped(dropped), .remaining(remaining)
  );

  pulse_stretch_timer #(.PRESCALE(1), .CNT_W(W), .COOL_TICKS(C)) u_dut_p1 (
    .clk(clk), .n_reset(n_reset), .trig_in(trig1), .cancel(zero1),
    .retrig_en(zero1), .hold_len(hold1), .level_out(level1),
    .done_pulse(done1), .dropped(drop1), .remaining(remaining1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Window ends at an absolute edge; triggers are refused until m_idle_from.
  task automatic model_edge();
    cyc++;
    m_done = 1'b0;
    m_drop = 1'b0;
    if (m_win) begin
      if (cancel) begin
        m_win = 1'b0;
        m_idle_from = cyc + C * P;
        m_drop = trig_in;
      end else if (trig_in && retrig_en && hold_len != 0) begin
        m_fall = cyc + int'(hold_len) * P;
      end else begin
        m_drop = trig_in;
        if (cyc == m_fall) begin
          m_win = 1'b0;
          m_done = 1'b1;
          m_idle_from = cyc + C * P;
        end
      end
    end else if (trig_in) begin
      if (cyc >= m_idle_from && !cancel && hold_len != 0) begin
        m_win = 1'b1;
        m_fall = cyc + int'(hold_len) * P;
      end else begin
        m_drop = 1'b1;
      end
    end
  endtask

  function automatic int m_rem();
    return m_win ? (m_fall - cyc + P - 1) / P : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("level", level_out, m_win);
    chk("done", done_pulse, m_done);
    chk("dropped", dropped, m_drop);
    chk("remaining", remaining, m_rem());
    if (level_out === 1'b1) hi_cnt++;
    if (done_pulse === 1'b1) done_cnt++;
    if (dropped === 1'b1) drop_cnt++;
  endtask

  task automatic pulse(input bit t, input bit c, input bit r, input int h);
    trig_in = t;
    cancel = c;
    retrig_en = r;
    hold_len = W'(h);
    step();
    trig_in = 1'b0;
    cancel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic clr_cnt();
    hi_cnt = 0;
    done_cnt = 0;
    drop_cnt = 0;
  endtask

  initial begin
    #22;
    chk("rst_level", level_out, 0);
    chk("rst_done", done_pulse, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_remaining", remaining, 0);
    n_reset = 1'b1;
    idle(3);

    // Basic window
    clr_cnt();
    pulse(1, 0, 0, 3);
    chk("basic_rem_start", remaining, 3);
    idle(20);
    chk("basic_high", hi_cnt, 12);
    chk("basic_done", done_cnt, 1);

    // Retrigger accepted 8 cycles in
    clr_cnt();
    pulse(1, 0, 1, 3);
    idle(7);
    pulse(1, 0, 1, 3);
    idle(30);
    chk("retrig_high", hi_cnt, 20);
    chk("retrig_done", done_cnt, 1);

    // Retrigger refused
    clr_cnt();
    pulse(1, 0, 0, 3);
    idle(7);
    pulse(1, 0, 0, 3);
    chk("noretrig_drop", dropped, 1);
    idle(30);
    chk("noretrig_high", hi_cnt, 12);
    chk("noretrig_done", done_cnt, 1);

    // Cancel mid-window, then cancel with trigger in IDLE
    clr_cnt();
    pulse(1, 0, 0, 3);
    idle(4);
    pulse(0, 1, 0, 3);
    chk("cancel_level", level_out, 0);
    idle(12);
    chk("cancel_high", hi_cnt, 5);
    chk("cancel_done", done_cnt, 0);
    clr_cnt();
    pulse(1, 1, 0, 3);
    chk("cancel_idle_drop", dropped, 1);
    idle(3);
    chk("cancel_idle_high", hi_cnt, 0);

    // Cooldown: early trigger dropped, trigger at the gap boundary accepted
    pulse(1, 0, 0, 3);
    idle(12);
    idle(3);
    pulse(1, 0, 0, 3);
    chk("cool_early_drop", dropped, 1);
    idle(3);
    pulse(1, 0, 0, 3);
    chk("cool_accept", level_out, 1);
    idle(24);
    pulse(1, 0, 0, 0);
    chk("zero_len_drop", dropped, 1);
    chk("zero_len_level", level_out, 0);
    idle(2);

    // Retrigger on the expiring tick
    clr_cnt();
    pulse(1, 0, 1, 2);
    idle(7);
    pulse(1, 0, 1, 2);
    chk("exp_retrig_level", level_out, 1);
    chk("exp_retrig_done", done_pulse, 0);
    idle(20);
    chk("exp_retrig_high", hi_cnt, 16);
    chk("exp_retrig_cnt", done_cnt, 1);

    // Asynchronous reset mid-window
    pulse(1, 0, 0, 5);
    idle(6);
    #2 n_reset = 1'b0;
    #1;
    chk("mid_rst_level", level_out, 0);
    chk("mid_rst_done", done_pulse, 0);
    chk("mid_rst_dropped", dropped, 0);
    chk("mid_rst_remaining", remaining, 0);
    #3 n_reset = 1'b1;
    m_win = 1'b0;
    m_done = 1'b0;
    m_drop = 1'b0;
    m_idle_from = 0;
    pulse(1, 0, 0, 2);
    chk("post_rst_accept", level_out, 1);
    idle(20);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      trig_in = ($urandom_range(0, 7) == 0);
      cancel = ($urandom_range(0, 31) == 0);
      retrig_en = 1'($urandom_range(0, 1));
      hold_len = W'($urandom_range(0, 6));
      step();
    end
    trig_in = 1'b0;
    cancel = 1'b0;
    idle(40);

    // PRESCALE=1 instance, longest window
    hold1 = 8'd255;
    trig1 = 1'b1;
    step();
    trig1 = 1'b0;
    chk("p1_rem_start", remaining1, 255);
    n1 = 0;
    for (int i = 0; i < 400 && level1 === 1'b1; i++) begin
      n1++;
      step();
    end
    chk("p1_len", n1, 255);
    chk("p1_done", done1, 1);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
